conv1_buf: RTL and testbench

CONV1_BUF -- requirements
Module: conv1_buf

---
 rtl/conv1_buf.sv | 121 ++++++++++++
 tb/tb_conv1_buf.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv1_buf.sv
// conv1_buf: 3x3 sliding-window line buffer for a binarized image stream.
// Pixels arrive in raster order. A 2*IMG_W+3 bit shift register holds the
// last two rows plus three pixels, so the nine window taps always line up
// as a 3x3 neighbourhood of the newest pixel. Row/column counters track the
// position of the next pixel. They flag windows that lie fully inside the
// image, and the final window of each frame.
// The window outputs are driven straight from the shift-register flops.
// They are therefore registered, and they hold still whenever in_valid is low.
// The design assumes IMG_W >= 3 and IMG_H >= 3.

module conv1_buf #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic pixel_in,
    input  logic sof,
    output logic pixel_0,
    output logic pixel_1,
    output logic pixel_2,
    output logic pixel_3,
    output logic pixel_4,
    output logic pixel_5,
    output logic pixel_6,
    output logic pixel_7,
    output logic pixel_8,
    output logic valid_out_buf,
    output logic frame_done
);

    localparam int SR_LEN = 2 * IMG_W + 3;
    localparam int CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    logic [SR_LEN-1:0] taps;

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    logic [CW-1:0] cur_col;
    logic [RW-1:0] cur_row;
    logic [CW-1:0] next_col;
    logic [RW-1:0] next_row;
    logic          win_ok;
    logic          last_px;

    // Position of the pixel on the input this cycle (sof forces it to the frame origin),
    // the position that follows it, and whether it completes an in-image window.
    always_comb begin
        cur_col  = col;
        cur_row  = row;
        next_col = '0;
        next_row = '0;
        if (sof) begin
            cur_col = '0;
            cur_row = '0;
        end
        if (cur_col == COL_LAST) begin
            next_col = '0;
            if (cur_row == ROW_LAST) begin
                next_row = '0;
            end else begin
                next_row = cur_row + RW'(1);
            end
        end else begin
            next_col = cur_col + CW'(1);
            next_row = cur_row;
        end
        win_ok  = (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
        last_px = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
    end

    // Line buffer: each accepted pixel enters at tap 0 and everything ages by one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taps <= '0;
        end else if (in_valid) begin
            taps <= {taps[SR_LEN-2:0], pixel_in};
        end
    end

    // Raster position counters, advanced only on accepted pixels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (in_valid) begin
            col <= next_col;
            row <= next_row;
        end
    end

    // Window-valid and end-of-frame flags, one cycle after the pixel that completes the window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out_buf <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            valid_out_buf <= in_valid && win_ok;
            frame_done    <= in_valid && last_px;
        end
    end

    assign pixel_8 = taps[0];
    assign pixel_7 = taps[1];
    assign pixel_6 = taps[2];
    assign pixel_5 = taps[IMG_W];
    assign pixel_4 = taps[IMG_W + 1];
    assign pixel_3 = taps[IMG_W + 2];
    assign pixel_2 = taps[2 * IMG_W];
    assign pixel_1 = taps[2 * IMG_W + 1];
    assign pixel_0 = taps[2 * IMG_W + 2];

endmodule

// File: tb/tb_conv1_buf.sv
// tb_conv1_buf: directed bench for the 3x3 window line buffer.
// A monitor logs every valid window and every frame_done pulse. Each test task
// drives frames and compares the log against windows rebuilt from the
// pixel pattern by image coordinates.

module tb_conv1_buf;

    localparam int W = 28;
    localparam int H = 28;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic pixel_in;
    logic sof;
    logic pixel_0, pixel_1, pixel_2, pixel_3, pixel_4;
    logic pixel_5, pixel_6, pixel_7, pixel_8;
    logic valid_out_buf;
    logic frame_done;

    int n_checks = 0;
    int n_pass   = 0;

    logic [8:0] win_q[$];
    logic [8:0] exp_q[$];
    int         fd_cnt      = 0;
    int         fd_last_idx = -1;
    int         fd_orphan   = 0;
    int         idle_bad    = 0;
    logic       last_acc;
    logic [8:0] cur_win;

    always #5 clk = ~clk;

    conv1_buf #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .pixel_in(pixel_in),
        .sof(sof),
        .pixel_0(pixel_0),
        .pixel_1(pixel_1),
        .pixel_2(pixel_2),
        .pixel_3(pixel_3),
        .pixel_4(pixel_4),
        .pixel_5(pixel_5),
        .pixel_6(pixel_6),
        .pixel_7(pixel_7),
        .pixel_8(pixel_8),
        .valid_out_buf(valid_out_buf),
        .frame_done(frame_done)
    );

    assign cur_win = {pixel_8, pixel_7, pixel_6, pixel_5, pixel_4,
                      pixel_3, pixel_2, pixel_1, pixel_0};

    // Remember whether the previous edge accepted a pixel.
    always @(posedge clk or posedge rst) begin
        if (rst) last_acc <= 1'b0;
        else     last_acc <= in_valid;
    end

    // Log windows and frame_done pulses mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid_out_buf) begin
                win_q.push_back(cur_win);
                if (!last_acc) idle_bad++;
            end
            if (frame_done) begin
                fd_cnt++;
                fd_last_idx = win_q.size();
                if (!valid_out_buf) fd_orphan++;
            end
        end
    end

    function automatic logic pat(input int mode, input int r, input int c);
        case (mode)
            0:       return ((r + c) % 2) == 1;
            1:       return 1'b1;
            2:       return 1'b0;
            default: return ((r * 3 + c * 5) % 7) < 3;
        endcase
    endfunction

    // Expected window for newest pixel (r,c); bit i is pixel_i.
    function automatic logic [8:0] exp_win(input int mode, input int r, input int c);
        logic [8:0] w;
        for (int i = 0; i < 9; i++) w[i] = pat(mode, r - 2 + i / 3, c - 2 + i % 3);
        return w;
    endfunction

    function automatic int count_mm(input int base);
        int n = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i >= win_q.size()) n++;
            else if (win_q[base + i] !== exp_q[i]) n++;
        end
        return n;
    endfunction

    task automatic drive(input logic v, input logic p, input logic s);
        in_valid = v;
        pixel_in = p;
        sof      = s;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
    endtask

    // Send a frame up to and including (stop_r, stop_c), logging expected windows.
    task automatic send_frame(input int mode, input bit use_sof, input bit gap,
                              input int stop_r, input int stop_c);
        bit done = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (!done) begin
                    drive(1'b1, pat(mode, r, c), use_sof && r == 0 && c == 0);
                    if (r >= 2 && c >= 2) exp_q.push_back(exp_win(mode, r, c));
                    if (gap) drive(1'b0, ~pat(mode, r, c), 1'b1);
                    if (r == stop_r && c == stop_c) done = 1;
                end
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; pixel_in = 1'b0; sof = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (cur_win !== 9'b0) $display("FAIL reset_window: got %b expected %b", cur_win, 9'b0);
        else n_pass++;
        n_checks++;
        if (valid_out_buf !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid_out_buf);
        else n_pass++;
        n_checks++;
        if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b expected 0", frame_done);
        else n_pass++;
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_continuous;
        int base = win_q.size();
        int fd0  = fd_cnt;
        int ib0  = idle_bad;
        int fo0  = fd_orphan;
        exp_q.delete();
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                drive(1'b1, pat(0, r, c), r == 0 && c == 0);
                if (r >= 2 && c >= 2) exp_q.push_back(exp_win(0, r, c));
                if (r == 2 && c == 1) begin
                    n_checks++;
                    if (valid_out_buf !== 1'b0) $display("FAIL cont_before_first: got %b expected 0", valid_out_buf);
                    else n_pass++;
                end
                if (r == 2 && c == 2) begin
                    n_checks++;
                    if (valid_out_buf !== 1'b1) $display("FAIL cont_first_valid: got %b expected 1", valid_out_buf);
                    else n_pass++;
                    n_checks++;
                    if (cur_win !== 9'b010101010) $display("FAIL cont_first_window: got %b expected %b", cur_win, 9'b010101010);
                    else n_pass++;
                end
                if (r == 3 && c == 1) begin
                    n_checks++;
                    if (valid_out_buf !== 1'b0) $display("FAIL cont_row_wrap: got %b expected 0", valid_out_buf);
                    else n_pass++;
                end
                if (r == H - 1 && c == W - 2) begin
                    n_checks++;
                    if (frame_done !== 1'b0) $display("FAIL cont_fd_early: got %b expected 0", frame_done);
                    else n_pass++;
                end
                if (r == H - 1 && c == W - 1) begin
                    n_checks++;
                    if (frame_done !== 1'b1) $display("FAIL cont_fd_last: got %b expected 1", frame_done);
                    else n_pass++;
                end
            end
        end
        idle(3);
        n_checks++;
        if (win_q.size() - base !== 676) $display("FAIL cont_count: got %0d expected 676", win_q.size() - base);
        else n_pass++;
        n_checks++;
        if (fd_cnt - fd0 !== 1) $display("FAIL cont_fd_count: got %0d expected 1", fd_cnt - fd0);
        else n_pass++;
        n_checks++;
        if (fd_last_idx !== base + 676) $display("FAIL cont_fd_position: got %0d expected %0d", fd_last_idx, base + 676);
        else n_pass++;
        n_checks++;
        if (count_mm(base) !== 0) $display("FAIL cont_windows: got %0d wrong expected 0", count_mm(base));
        else n_pass++;
        n_checks++;
        if (idle_bad - ib0 + fd_orphan - fo0 !== 0) $display("FAIL cont_stray_pulses: got %0d expected 0", idle_bad - ib0 + fd_orphan - fo0);
        else n_pass++;
    endtask

    task automatic test_gapped;
        int base = win_q.size();
        int fd0  = fd_cnt;
        int ib0  = idle_bad;
        exp_q.delete();
        send_frame(3, 1'b1, 1'b1, H - 1, W - 1);
        idle(3);
        n_checks++;
        if (win_q.size() - base !== 676) $display("FAIL gap_count: got %0d expected 676", win_q.size() - base);
        else n_pass++;
        n_checks++;
        if (fd_cnt - fd0 !== 1) $display("FAIL gap_fd_count: got %0d expected 1", fd_cnt - fd0);
        else n_pass++;
        n_checks++;
        if (count_mm(base) !== 0) $display("FAIL gap_windows: got %0d wrong expected 0", count_mm(base));
        else n_pass++;
        n_checks++;
        if (idle_bad !== ib0) $display("FAIL gap_idle_valid: got %0d expected 0", idle_bad - ib0);
        else n_pass++;
        n_checks++;
        if (cur_win !== exp_win(3, H - 1, W - 1)) $display("FAIL gap_window_hold: got %b expected %b", cur_win, exp_win(3, H - 1, W - 1));
        else n_pass++;
        n_checks++;
        if (valid_out_buf !== 1'b0) $display("FAIL gap_idle_valid_out: got %b expected 0", valid_out_buf);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int base = win_q.size();
        int fd0  = fd_cnt;
        exp_q.delete();
        send_frame(0, 1'b0, 1'b0, H - 1, W - 1);
        send_frame(3, 1'b0, 1'b0, H - 1, W - 1);
        idle(3);
        n_checks++;
        if (win_q.size() - base !== 1352) $display("FAIL b2b_count: got %0d expected 1352", win_q.size() - base);
        else n_pass++;
        n_checks++;
        if (fd_cnt - fd0 !== 2) $display("FAIL b2b_fd_count: got %0d expected 2", fd_cnt - fd0);
        else n_pass++;
        n_checks++;
        if (fd_last_idx !== base + 1352) $display("FAIL b2b_fd_position: got %0d expected %0d", fd_last_idx, base + 1352);
        else n_pass++;
        n_checks++;
        if (count_mm(base) !== 0) $display("FAIL b2b_windows: got %0d wrong expected 0", count_mm(base));
        else n_pass++;
    endtask

    task automatic test_sof_restart;
        int base = win_q.size();
        int fd0  = fd_cnt;
        exp_q.delete();
        send_frame(3, 1'b1, 1'b0, 10, 5);
        n_checks++;
        if (fd_cnt !== fd0) $display("FAIL sof_abandoned_fd: got %0d expected 0", fd_cnt - fd0);
        else n_pass++;
        send_frame(0, 1'b1, 1'b0, H - 1, W - 1);
        idle(3);
        n_checks++;
        if (win_q.size() - base !== 888) $display("FAIL sof_count: got %0d expected 888", win_q.size() - base);
        else n_pass++;
        n_checks++;
        if (fd_cnt - fd0 !== 1) $display("FAIL sof_fd_count: got %0d expected 1", fd_cnt - fd0);
        else n_pass++;
        n_checks++;
        if (count_mm(base) !== 0) $display("FAIL sof_windows: got %0d wrong expected 0", count_mm(base));
        else n_pass++;
    endtask

    task automatic test_constant;
        for (int m = 1; m <= 2; m++) begin
            int base = win_q.size();
            exp_q.delete();
            send_frame(m, 1'b1, 1'b0, H - 1, W - 1);
            idle(2);
            n_checks++;
            if (win_q.size() - base !== 676) $display("FAIL const%0d_count: got %0d expected 676", m, win_q.size() - base);
            else n_pass++;
            n_checks++;
            if (count_mm(base) !== 0) $display("FAIL const%0d_windows: got %0d wrong expected 0", m, count_mm(base));
            else n_pass++;
        end
    endtask

    task automatic test_async_reset;
        int base = win_q.size();
        int fd0  = fd_cnt;
        exp_q.delete();
        send_frame(3, 1'b1, 1'b0, 15, 7);
        n_checks++;
        if (valid_out_buf !== 1'b1) $display("FAIL arst_pre_valid: got %b expected 1", valid_out_buf);
        else n_pass++;
        void'(exp_q.pop_back());
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (cur_win !== 9'b0) $display("FAIL arst_window: got %b expected %b", cur_win, 9'b0);
        else n_pass++;
        n_checks++;
        if (valid_out_buf !== 1'b0) $display("FAIL arst_valid: got %b expected 0", valid_out_buf);
        else n_pass++;
        @(posedge clk);
        #3 rst = 1'b0;
        idle(2);
        send_frame(0, 1'b0, 1'b0, H - 1, W - 1);
        idle(3);
        n_checks++;
        if (win_q.size() - base !== 1019) $display("FAIL arst_count: got %0d expected 1019", win_q.size() - base);
        else n_pass++;
        n_checks++;
        if (fd_cnt - fd0 !== 1) $display("FAIL arst_fd_count: got %0d expected 1", fd_cnt - fd0);
        else n_pass++;
        n_checks++;
        if (count_mm(base) !== 0) $display("FAIL arst_windows: got %0d wrong expected 0", count_mm(base));
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_gapped();
        test_back_to_back();
        test_sof_restart();
        test_constant();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
